fifo_reader: RTL and testbench

FIFO_READER -- requirements
Module: fifo_reader

---
 rtl/fifo_reader.sv | 88 ++++++++
 tb/tb_fifo_reader.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_reader.sv
// FIFO read-side controller: issues memory reads, captures the returned word and holds it until
// downstream accepts. Optional delivered-word counter enabled by macro FIFO_READER_CNT_EN.
module fifo_reader #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_en,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              fifo_rd,
    output logic [4:0]        rptr,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready
`ifdef FIFO_READER_CNT_EN
    ,
    output logic [15:0]       rd_count
`endif
);

    typedef enum logic [1:0] {
        StIdle,
        StWaitData,
        StValid
    } state_e;

    state_e state_q;
    logic   issue;

    // A new read may start from idle, or in the same cycle the held word is accepted.
    always_comb begin
        issue = 1'b0;
        unique case (state_q)
            StIdle:     issue = rd_en & ~fifo_empty;
            StValid:    issue = out_ready & rd_en & ~fifo_empty;
            default:    issue = 1'b0;
        endcase
    end

    assign fifo_rd = issue & rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            rptr      <= 5'd0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            if (fifo_rd) begin
                rptr <= rptr + 5'd1;
            end
            unique case (state_q)
                StIdle: begin
                    if (issue) begin
                        state_q <= StWaitData;
                    end
                end
                StWaitData: begin
                    out_data  <= mem_rdata;
                    out_valid <= 1'b1;
                    state_q   <= StValid;
                end
                StValid: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state_q   <= issue ? StWaitData : StIdle;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state_q   <= StIdle;
                end
            endcase
        end
    end

`ifdef FIFO_READER_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_count <= 16'd0;
        end else if (out_valid && out_ready) begin
            rd_count <= rd_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// Directed + random bench for fifo_reader with a synchronous memory model and a data scoreboard.
// Define FIFO_READER_CNT_EN for both files to exercise rd_count.
module tb_fifo_reader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rd_en;
    logic       fifo_empty;
    logic [7:0] mem_rdata;
    logic       fifo_rd;
    logic [4:0] rptr;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
`ifdef FIFO_READER_CNT_EN
    logic [15:0] rd_count;
`endif

    fifo_reader #(.DATA_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_en      (rd_en),
        .fifo_empty (fifo_empty),
        .mem_rdata  (mem_rdata),
        .fifo_rd    (fifo_rd),
        .rptr       (rptr),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready)
`ifdef FIFO_READER_CNT_EN
        ,
        .rd_count   (rd_count)
`endif
    );

    always #5 clk = ~clk;

    int         n_chk = 0;
    int         n_err = 0;
    logic [7:0] mem [16];
    logic [7:0] sb [$];
    logic [4:0] exp_ptr = 5'd0;
    logic [15:0] exp_cnt = 16'd0;
    int         delivered = 0;
    int         mst = 0;  // 0 idle, 1 waiting for data, 2 holding a valid word
    logic       exp_rd = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        assert (got === want)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    // Synchronous memory: data appears the cycle after the strobe.
    always @(posedge clk) begin
        if (fifo_rd === 1'b1) mem_rdata <= mem[rptr[3:0]];
    end

    // Mid-cycle monitor: strobe/valid protocol, scoreboard push on read, pop on acceptance.
    always @(negedge clk) begin
        exp_rd = rst_n && rd_en && !fifo_empty && (mst == 0 || (mst == 2 && out_ready));
        chk("fifo_rd", {31'd0, fifo_rd}, {31'd0, exp_rd});
        chk("out_valid", {31'd0, out_valid}, {31'd0, (mst == 2)});
        if (fifo_rd === 1'b1) begin
            sb.push_back(mem[exp_ptr[3:0]]);
            exp_ptr = exp_ptr + 5'd1;
        end
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", {24'd0, out_data}, 32'hFFFF_FFFF);
            end else begin
                chk("out_data", {24'd0, out_data}, {24'd0, sb.pop_front()});
            end
            delivered++;
            exp_cnt = exp_cnt + 16'd1;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) mst <= 0;
        else if (mst == 0) mst <= exp_rd ? 1 : 0;
        else if (mst == 1) mst <= 2;
        else if (out_ready) mst <= exp_rd ? 1 : 0;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic reset_model();
        sb.delete();
        exp_ptr = 5'd0;
        exp_cnt = 16'd0;
    endtask

    initial begin
        int d0;
        for (int i = 0; i < 16; i++) mem[i] = 8'(i * 7 + 3);
        rst_n = 1'b0; rd_en = 1'b1; fifo_empty = 1'b0; out_ready = 1'b0;
        reset_model();
        #12;
        // Reset state, strobe suppressed even with a read request pending
        chk("rst_fifo_rd", {31'd0, fifo_rd}, 32'd0);
        chk("rst_rptr", {27'd0, rptr}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", {24'd0, out_data}, 32'd0);
`ifdef FIFO_READER_CNT_EN
        chk("rst_rd_count", {16'd0, rd_count}, 32'd0);
`endif
        fifo_empty = 1'b1;
        step(2);
        rst_n = 1'b1;

        // Empty FIFO: no read for 10 cycles
        for (int i = 0; i < 10; i++) begin
            step(1);
            chk("empty_fifo_rd", {31'd0, fifo_rd}, 32'd0);
            chk("empty_rptr", {27'd0, rptr}, 32'd0);
            chk("empty_out_valid", {31'd0, out_valid}, 32'd0);
        end

        // Single read: strobe at cycle 0, word at cycle 2
        mem[0] = 8'hA5;
        fifo_empty = 1'b0; out_ready = 1'b1;
        #1 chk("c0_fifo_rd", {31'd0, fifo_rd}, 32'd1);
        step(1);
        fifo_empty = 1'b1;
        chk("c1_rptr", {27'd0, rptr}, 32'd1);
        chk("c1_out_valid", {31'd0, out_valid}, 32'd0);
        step(1);
        chk("c2_out_valid", {31'd0, out_valid}, 32'd1);
        chk("c2_out_data", {24'd0, out_data}, 32'hA5);
        step(1);
        chk("c3_out_valid", {31'd0, out_valid}, 32'd0);

        // Backpressure: word held for 5 cycles with a read available
        mem[1] = 8'h3C; out_ready = 1'b0; fifo_empty = 1'b0;
        step(1);
        fifo_empty = 1'b1;
        step(1);
        fifo_empty = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("hold_out_data", {24'd0, out_data}, 32'h3C);
            chk("hold_fifo_rd", {31'd0, fifo_rd}, 32'd0);
            chk("hold_rptr", {27'd0, rptr}, 32'd2);
            step(1);
        end
        fifo_empty = 1'b1; out_ready = 1'b1;
        step(1);
        chk("hold_released", {31'd0, out_valid}, 32'd0);

        // 34 back-to-back reads across the pointer wrap
        rst_n = 1'b0; reset_model();
        #2 rst_n = 1'b1;
        for (int i = 0; i < 16; i++) mem[i] = 8'(i * 13 + 1);
        step(1);
        fifo_empty = 1'b0; rd_en = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 68; i++) begin
            if (i == 67) fifo_empty = 1'b1;
            #1;
            chk("b2b_fifo_rd", {31'd0, fifo_rd}, {31'd0, (i % 2 == 0) && (i < 67)});
            chk("b2b_rptr", {27'd0, rptr}, 32'(((i + 1) / 2) % 32));
            step(1);
        end
        step(2);
        chk("b2b_final_rptr", {27'd0, rptr}, 32'd2);
        chk("b2b_drained", 32'(sb.size()), 32'd0);

        // Reset while waiting for data discards the word
        d0 = delivered;
        fifo_empty = 1'b0;
        step(1);
        fifo_empty = 1'b1;
        rst_n = 1'b0; reset_model();
        #2 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1);
            chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
            chk("abort_rptr", {27'd0, rptr}, 32'd0);
        end
        chk("abort_delivered", 32'(delivered), 32'(d0));

        // Three accepted words
        fifo_empty = 1'b0;
        step(5);
        fifo_empty = 1'b1;
        step(2);
        chk("three_rptr", {27'd0, rptr}, 32'd3);
`ifdef FIFO_READER_CNT_EN
        chk("three_rd_count", {16'd0, rd_count}, 32'd3);
`endif

        // Random traffic with backpressure and empty toggling
        for (int i = 0; i < 16; i++) mem[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 300; i++) begin
            rd_en = ($urandom_range(0, 3) != 0);
            fifo_empty = ($urandom_range(0, 3) == 0);
            out_ready = $urandom_range(0, 1) != 0;
            step(1);
        end
        rd_en = 1'b0; out_ready = 1'b1;
        step(4);
        chk("rand_drained", 32'(sb.size()), 32'd0);
        chk("rand_rptr", {27'd0, rptr}, {27'd0, exp_ptr});
`ifdef FIFO_READER_CNT_EN
        chk("rand_rd_count", {16'd0, rd_count}, {16'd0, exp_cnt});
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
